// File: rtl/bcd_updown_counter_if.sv
// Request/status bundle between the gate-side adapter and the BCD occupancy counter.
// The master issues tick/sign requests; the slave returns the count and its status flags.
interface bcd_updown_counter_if #(
    parameter int NDIG = 2
);
    logic              tick;
    logic              sign;
    logic [4*NDIG-1:0] count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    modport master (
        output tick,
        output sign,
        input  count,
        input  full,
        input  empty,
        input  ovf,
        input  unf
    );

    modport slave (
        input  tick,
        input  sign,
        output count,
        output full,
        output empty,
        output ovf,
        output unf
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Saturating multi-digit BCD up/down occupancy counter with full/empty flags and ovf/unf pulses.
// Each request is classified in the same cycle; there are no multi-cycle states.
//
//   decision | meaning
//   ACCEPT   | tick applied: count moves one step in BCD
//   REJECT   | up while full or down while empty: count holds, ovf/unf pulses
module bcd_updown_counter #(
    parameter int NDIG     = 2,
    parameter int CAPACITY = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_updown_counter_if.slave  bus
);
    localparam int W = 4 * NDIG;

    if (CAPACITY < 1 || CAPACITY > (10 ** NDIG) - 1) begin : g_capacity_check
        $error("bcd_updown_counter: CAPACITY %0d out of range for NDIG %0d", CAPACITY, NDIG);
    end

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] CAP_BCD = to_bcd(CAPACITY);

    typedef enum logic {
        ACCEPT = 1'b0,
        REJECT = 1'b1
    } req_e;

    logic [W-1:0] count_q;
    logic [W-1:0] count_inc;
    logic [W-1:0] count_dec;
    logic [W-1:0] count_next;
    logic         ovf_q;
    logic         unf_q;
    logic         ovf_next;
    logic         unf_next;
    logic         full;
    logic         empty;
    req_e         req;

    assign full  = (count_q == CAP_BCD);
    assign empty = (count_q == '0);

    // Carry ripples through consecutive 9 digits in one cycle.
    always_comb begin : p_increment
        logic       carry;
        logic [3:0] d;
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = count_q[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = d + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Borrow ripples through consecutive 0 digits in one cycle.
    always_comb begin : p_decrement
        logic       borrow;
        logic [3:0] d;
        count_dec = count_q;
        borrow    = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = count_q[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = d - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    always_comb begin : p_decide
        req        = ACCEPT;
        count_next = count_q;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (bus.tick) begin
            if (bus.sign ? full : empty) begin
                req = REJECT;
            end
            case (req)
                ACCEPT: count_next = bus.sign ? count_inc : count_dec;
                REJECT: begin
                    ovf_next = bus.sign;
                    unf_next = !bus.sign;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            ovf_q   <= ovf_next;
            unf_q   <= unf_next;
        end
    end

    assign bus.count = count_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (NDIG=2, CAPACITY=25): directed scenarios
// plus a randomized run against a decimal-integer reference model.
module tb_bcd_updown_counter;
    localparam int NDIG     = 2;
    localparam int CAPACITY = 25;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: occupancy as a plain integer, pulses as expected flags.
    int   m_count;
    logic m_ovf;
    logic m_unf;

    bcd_updown_counter_if #(.NDIG(NDIG)) bif ();

    bcd_updown_counter #(.NDIG(NDIG), .CAPACITY(CAPACITY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*NDIG-1:0] to_bcd(input int value);
        logic [4*NDIG-1:0] r;
        int                v;
        r = '0;
        v = value;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // One clock: drive on the falling edge, update model at the rising edge, settle 1 time unit.
    task automatic drive(input logic r, input logic t, input logic s);
        @(negedge clk);
        reset    = r;
        bif.tick = t;
        bif.sign = s;
        @(posedge clk);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (r) begin
            m_count = 0;
        end else if (t) begin
            if (s) begin
                if (m_count == CAPACITY) m_ovf = 1'b1;
                else m_count = m_count + 1;
            end else begin
                if (m_count == 0) m_unf = 1'b1;
                else m_count = m_count - 1;
            end
        end
        #1;
    endtask

    task automatic goto_count(input int n);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bif.count !== 8'h00 || bif.empty !== 1'b1 || bif.full !== 1'b0 ||
            bif.ovf !== 1'b0 || bif.unf !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%h empty=%b full=%b ovf=%b unf=%b required 00 1 0 0 0",
                     bif.count, bif.empty, bif.full, bif.ovf, bif.unf);
        end
    endtask

    task automatic test_count_up;
        logic [7:0] exp;
        goto_count(0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            exp = (i < 9) ? 8'(i + 1) : 8'h10;
            checks++;
            if (bif.count !== exp || bif.empty !== 1'b0) begin
                errors++;
                $display("FAIL count_up[%0d]: count=%h empty=%b required %h 0", i, bif.count, bif.empty, exp);
            end
        end
    endtask

    task automatic test_saturate;
        goto_count(25);
        checks++;
        if (bif.count !== 8'h25 || bif.full !== 1'b1 || bif.ovf !== 1'b0) begin
            errors++;
            $display("FAIL at_capacity: count=%h full=%b ovf=%b required 25 1 0", bif.count, bif.full, bif.ovf);
        end
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (bif.count !== 8'h25 || bif.full !== 1'b1 || bif.ovf !== 1'b1) begin
            errors++;
            $display("FAIL saturate: count=%h full=%b ovf=%b required 25 1 1", bif.count, bif.full, bif.ovf);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bif.count !== 8'h25 || bif.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_one_cycle: count=%h ovf=%b required 25 0", bif.count, bif.ovf);
        end
    endtask

    task automatic test_down;
        goto_count(10);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (bif.count !== 8'h09) begin
            errors++;
            $display("FAIL borrow: count=%h required 09", bif.count);
        end
        goto_count(0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (bif.count !== 8'h00 || bif.unf !== 1'b1 || bif.empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: count=%h unf=%b empty=%b required 00 1 1", bif.count, bif.unf, bif.empty);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.unf !== 1'b0 || bif.count !== 8'h00) begin
            errors++;
            $display("FAIL unf_one_cycle: count=%h unf=%b required 00 0", bif.count, bif.unf);
        end
    endtask

    task automatic test_hold;
        goto_count(17);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'(i % 2));
            checks++;
            if (bif.count !== 8'h17 || bif.ovf !== 1'b0 || bif.unf !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: count=%h ovf=%b unf=%b required 17 0 0", i, bif.count, bif.ovf, bif.unf);
            end
        end
    endtask

    task automatic test_reset_with_tick;
        goto_count(19);
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bif.count !== 8'h00 || bif.empty !== 1'b1 || bif.ovf !== 1'b0 || bif.unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: count=%h empty=%b ovf=%b unf=%b required 00 1 0 0",
                     bif.count, bif.empty, bif.ovf, bif.unf);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        goto_count(24);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, (i % 2) == 0);
            exp = ((i % 2) == 0) ? 8'h25 : 8'h24;
            checks++;
            if (bif.count !== exp || bif.full !== ((i % 2) == 0) || bif.ovf !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back[%0d]: count=%h full=%b ovf=%b required %h %b 0",
                         i, bif.count, bif.full, bif.ovf, exp, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_random;
        logic r, t, s;
        goto_count(0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            t = ($urandom_range(0, 3) != 0);
            // Bias direction in long runs so both saturation ends get exercised.
            s = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive(r, t, s);
            checks++;
            if (bif.count !== to_bcd(m_count) || bif.full !== (m_count == CAPACITY) ||
                bif.empty !== (m_count == 0) || bif.ovf !== m_ovf || bif.unf !== m_unf) begin
                errors++;
                $display("FAIL random[%0d]: count=%h full=%b empty=%b ovf=%b unf=%b required %h %b %b %b %b",
                         i, bif.count, bif.full, bif.empty, bif.ovf, bif.unf, to_bcd(m_count),
                         m_count == CAPACITY, m_count == 0, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_count  = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        reset    = 1'b1;
        bif.tick = 1'b0;
        bif.sign = 1'b0;
        test_reset;
        test_count_up;
        test_saturate;
        test_down;
        test_hold;
        test_reset_with_tick;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
